pe_array_core: RTL and testbench
================================

// Module: pe_array_core
// PURPOSE
//  Processing-element array of NUM_PE PEs, each with NUM_LANES streaming execution lanes.
//  Per PE, an out-of-band (OOB) command starts a lane-parallel streaming operation.
//  Each lane consumes two standard operand streams (stream0, stream1), reduces them to one
//  32-bit result and writes that result to local memory through a DMA write port.
//  Sits between the system stack-bus lane interfaces and the per-lane memory controllers.
// PARAMETERS
//  NUM_PE     4   number of PEs (system build uses 64)
//  NUM_LANES  2   execution lanes per PE (system build uses 32)
//  DATA_W     32  stream element / result width
//  ADDR_W     24  memory word-address width
// PORTS  (lane index i = pe*NUM_LANES+lane; vectors are flattened, index 0 in the LSBs)
//  clk                           in   1              single clock, rising edge
//  reset_poweron                 in   1              synchronous, active-high reset
//  oob__pe__valid                in   NUM_PE         command valid, one per PE
//  oob__pe__op                   in   2*NUM_PE       0=NOP 1=MAC 2=ADD 3=reserved(NOP)
//  oob__pe__base_addr            in   ADDR_W*NUM_PE  result base word address
//  pe__oob__ready                out  NUM_PE         PE idle, command accepted
//  std__pe__strm0_valid          in   NUM_PE*NUM_LANES          stream0 element valid
//  std__pe__strm0_data           in   DATA_W*NUM_PE*NUM_LANES   stream0 element
//  std__pe__strm0_cntl           in   2*NUM_PE*NUM_LANES  00 mid, 01 SOD, 10 EOD, 11 SOD+EOD
//  std__pe__strm1_valid/_data    in   as stream0     stream1 (its cntl is not used)
//  pe__std__strm_ready           out  NUM_PE*NUM_LANES   lane pops both streams
//  dma__memc__write_valid        out  NUM_PE*NUM_LANES   result write request
//  dma__memc__write_address      out  ADDR_W*NUM_PE*NUM_LANES
//  dma__memc__write_data         out  DATA_W*NUM_PE*NUM_LANES
//  memc__dma__write_ready        in   NUM_PE*NUM_LANES   memory accepts write
// BEHAVIOUR
//  Reset: all lanes IDLE, accumulators 0; pe__oob__ready=1; strm_ready=0; write_valid=0;
//   write_address and write_data are 0. A reset mid-operation aborts it with no write.
//  Command: accepted when oob__pe__valid && pe__oob__ready. NOP and op 3 are accepted
//   with no effect. MAC and ADD latch op and base_addr, and move all lanes of that PE to ACCUM.
//   pe__oob__ready drops the cycle after acceptance and stays low until all lanes are IDLE.
//  Lane FSM: IDLE -> ACCUM -> WRITE -> IDLE.
//   ACCUM: strm_ready=1. An element is consumed in a cycle with strm0_valid && strm1_valid
//    (ready is already high). A consumed element with SOD set first clears the accumulator.
//    MAC:  acc = acc + s0*s1 (signed multiply, low DATA_W bits, wraps mod 2^DATA_W).
//    ADD:  acc = acc + s0 + s1 (mod 2^DATA_W).
//    Elements with valid on only one stream are not consumed; both streams stall.
//    Consuming an element with EOD set moves the lane to WRITE the next cycle,
//     with the final acc (this element included).
//   WRITE: strm_ready=0. write_valid=1, write_address = base_addr + lane (mod 2^ADDR_W),
//    write_data = acc. Outputs are held stable until memc__dma__write_ready=1 (ready may
//    already be high in the first cycle). Then the lane returns to IDLE (write_valid=0 next cycle).
//  Latency: the EOD element is consumed at cycle N; write_valid is first high at cycle N+1.
//  Lanes run independently. The PE finishes when its last lane's write is accepted.
//  IDLE lanes ignore stream valid (strm_ready=0).
// TESTING
//  Reset: hold reset_poweron 10 cycles -> pe__oob__ready all 1, write_valid all 0.
//  MAC, PE0, base 0x100; lane0 s0={1,2,3,4}, s1={5,6,7,8} (SOD..EOD)
//   -> single write: addr 0x100, data 70.
//  ADD, PE1 lane1; s0={-1}, s1={3} with cntl 11 -> write: addr base+1, data 2.
//  Write backpressure: hold memc__dma__write_ready=0 for 5 cycles
//   -> write_valid, addr and data held stable, one write on release.
//  Stream stall: s1 valid gap of 3 cycles mid-vector -> result identical to the no-gap case.
//  Overflow: MAC 0x7FFFFFFF*2 + 2 (two elements) -> data 0x00000000.

Source files
------------

// File: rtl/pe_array_core.sv
// pe_array_core: PE array of streaming MAC/ADD lanes, each writing one reduced result to memory
module pe_array_core #(
  parameter int NUM_PE    = 4,
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 24
) (
  input  logic                               clk,
  input  logic                               reset_poweron,
  input  logic [NUM_PE-1:0]                  oob__pe__valid,
  input  logic [2*NUM_PE-1:0]                oob__pe__op,
  input  logic [ADDR_W*NUM_PE-1:0]           oob__pe__base_addr,
  output logic [NUM_PE-1:0]                  pe__oob__ready,
  input  logic [NUM_PE*NUM_LANES-1:0]        std__pe__strm0_valid,
  input  logic [DATA_W*NUM_PE*NUM_LANES-1:0] std__pe__strm0_data,
  input  logic [2*NUM_PE*NUM_LANES-1:0]      std__pe__strm0_cntl,
  input  logic [NUM_PE*NUM_LANES-1:0]        std__pe__strm1_valid,
  input  logic [DATA_W*NUM_PE*NUM_LANES-1:0] std__pe__strm1_data,
  output logic [NUM_PE*NUM_LANES-1:0]        pe__std__strm_ready,
  output logic [NUM_PE*NUM_LANES-1:0]        dma__memc__write_valid,
  output logic [ADDR_W*NUM_PE*NUM_LANES-1:0] dma__memc__write_address,
  output logic [DATA_W*NUM_PE*NUM_LANES-1:0] dma__memc__write_data,
  input  logic [NUM_PE*NUM_LANES-1:0]        memc__dma__write_ready
);
  typedef enum logic [1:0] {IDLE, ACCUM, WRITE} state_t;
  logic [NUM_PE*NUM_LANES-1:0] idle;
  for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
    logic [1:0] op;
    logic start, mac_q, mac_d;
    logic [ADDR_W-1:0] base_q, base_d;
    assign op = oob__pe__op[2*p +: 2];
    assign pe__oob__ready[p] = &idle[p*NUM_LANES +: NUM_LANES];
    assign start = oob__pe__valid[p] && pe__oob__ready[p] && (op == 2'd1 || op == 2'd2);
    always_comb begin
      mac_d  = start ? op == 2'd1 : mac_q;
      base_d = start ? oob__pe__base_addr[ADDR_W*p +: ADDR_W] : base_q;
    end
    always_ff @(posedge clk) begin
      if (reset_poweron) begin
        mac_q  <= 1'b0;
        base_q <= '0;
      end else begin
        mac_q  <= mac_d;
        base_q <= base_d;
      end
    end
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      localparam int I = p*NUM_LANES + l;
      state_t state_q, state_d;
      logic [DATA_W-1:0] acc_q, acc_d, s0, s1;
      logic [1:0] cntl;
      logic fire, wr_done;
      assign s0      = std__pe__strm0_data[DATA_W*I +: DATA_W];
      assign s1      = std__pe__strm1_data[DATA_W*I +: DATA_W];
      assign cntl    = std__pe__strm0_cntl[2*I +: 2];
      assign fire    = state_q == ACCUM && std__pe__strm0_valid[I] && std__pe__strm1_valid[I];
      assign wr_done = state_q == WRITE && memc__dma__write_ready[I];
      always_comb begin
        state_d = (state_q == IDLE && start) ? ACCUM :
                  (fire && cntl[1])          ? WRITE :
                  wr_done                    ? IDLE  : state_q;
        acc_d   = fire ? (cntl[0] ? '0 : acc_q) + (mac_q ? s0 * s1 : s0 + s1) : acc_q;
      end
      always_ff @(posedge clk) begin
        if (reset_poweron) begin
          state_q <= IDLE;
          acc_q   <= '0;
        end else begin
          state_q <= state_d;
          acc_q   <= acc_d;
        end
      end
      assign idle[I]                                    = state_q == IDLE;
      assign pe__std__strm_ready[I]                     = state_q == ACCUM;
      assign dma__memc__write_valid[I]                  = state_q == WRITE;
      assign dma__memc__write_address[ADDR_W*I +: ADDR_W] = state_q == WRITE ? base_q + ADDR_W'(l) : '0;
      assign dma__memc__write_data[DATA_W*I +: DATA_W]  = state_q == WRITE ? acc_q : '0;
    end
  end
endmodule

// File: tb/tb_pe_array_core.sv
// tb_pe_array_core: directed scoreboard bench for pe_array_core
module tb_pe_array_core;
  localparam int NP = 4;
  localparam int NLN = 2;
  localparam int DW = 32;
  localparam int AW = 24;
  localparam int NL = NP*NLN;
  typedef struct {int lane; logic [AW-1:0] addr; logic [DW-1:0] data;} exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0] ov, rdy;
  logic [2*NP-1:0] opv;
  logic [AW*NP-1:0] bv;
  logic [NL-1:0] s0v, s1v, sr, wv, wr;
  logic [DW*NL-1:0] s0d, s1d, wd;
  logic [2*NL-1:0] cn;
  logic [AW*NL-1:0] wa;
  exp_t sb[$];
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pe_array_core #(.NUM_PE(NP), .NUM_LANES(NLN), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_poweron(rst),
    .oob__pe__valid(ov), .oob__pe__op(opv), .oob__pe__base_addr(bv), .pe__oob__ready(rdy),
    .std__pe__strm0_valid(s0v), .std__pe__strm0_data(s0d), .std__pe__strm0_cntl(cn),
    .std__pe__strm1_valid(s1v), .std__pe__strm1_data(s1d), .pe__std__strm_ready(sr),
    .dma__memc__write_valid(wv), .dma__memc__write_address(wa), .dma__memc__write_data(wd),
    .memc__dma__write_ready(wr)
  );
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    int k;
    for (int i = 0; i < NL; i++) begin
      if (!rst && wv[i] && wr[i]) begin
        k = -1;
        foreach (sb[j]) if (k < 0 && sb[j].lane == i) k = j;
        chk($sformatf("write_expected_lane%0d", i), k >= 0, 1);
        if (k >= 0) begin
          chk($sformatf("wr_addr_lane%0d", i), wa[AW*i +: AW], sb[k].addr);
          chk($sformatf("wr_data_lane%0d", i), wd[DW*i +: DW], sb[k].data);
          sb.delete(k);
        end
      end
    end
  end
  task automatic cmd(int pe, logic [1:0] op, logic [AW-1:0] base);
    int t = 0;
    ov[pe] = 1'b1;
    opv[2*pe +: 2] = op;
    bv[AW*pe +: AW] = base;
    @(negedge clk);
    while (!rdy[pe] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_timeout", rdy[pe], 1);
    @(posedge clk);
    #1 ov[pe] = 1'b0;
  endtask
  task automatic send(int ln, logic [DW-1:0] a, logic [DW-1:0] b, logic [1:0] c, int gap);
    int t = 0;
    s0v[ln] = 1'b1;
    s1v[ln] = gap == 0;
    s0d[DW*ln +: DW] = a;
    s1d[DW*ln +: DW] = b;
    cn[2*ln +: 2] = c;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s1v[ln] = 1'b1;
    @(negedge clk);
    while (!sr[ln] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("strm_ready_timeout", sr[ln], 1);
    @(posedge clk);
    #1;
    s0v[ln] = 1'b0;
    s1v[ln] = 1'b0;
  endtask
  task automatic wait_idle(int pe);
    int t = 0;
    @(negedge clk);
    while (!rdy[pe] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", rdy[pe], 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    ov = '0; opv = '0; bv = '0;
    s0v = '0; s1v = '0; s0d = '0; s1d = '0; cn = '0;
    wr = '1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_oob_ready", rdy, 4'hF);
    chk("rst_write_valid", wv, 0);
    chk("rst_strm_ready", sr, 0);
    chk("rst_write_addr_zero", wa == '0, 1);
    chk("rst_write_data_zero", wd == '0, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    cmd(0, 2'd0, 24'h55);
    @(negedge clk);
    chk("nop_ready", rdy, 4'hF);
    chk("nop_strm_ready", sr, 0);
    @(posedge clk);
    #1;
    sb.push_back('{0, 24'h100, 32'd70});
    sb.push_back('{1, 24'h101, 32'd30});
    cmd(0, 2'd1, 24'h100);
    chk("ready_drop_after_accept", rdy[0], 0);
    send(1, 10, 3, 2'b11, 0);
    send(0, 1, 5, 2'b01, 0);
    send(0, 2, 6, 2'b00, 0);
    send(0, 3, 7, 2'b00, 0);
    send(0, 4, 8, 2'b10, 0);
    chk("eod_latency_write_valid", wv[0], 1);
    wait_idle(0);
    sb.push_back('{3, 24'h201, 32'd2});
    sb.push_back('{2, 24'h200, 32'd11});
    cmd(1, 2'd2, 24'h200);
    send(3, 32'hFFFF_FFFF, 3, 2'b11, 0);
    send(2, 5, 6, 2'b11, 0);
    wait_idle(1);
    wr[4] = 1'b0;
    sb.push_back('{4, 24'h300, 32'd6});
    sb.push_back('{5, 24'h301, 32'd16});
    cmd(2, 2'd1, 24'h300);
    send(4, 2, 3, 2'b11, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held", wv[4], 1);
      chk("bp_addr_held", wa[AW*4 +: AW], 24'h300);
      chk("bp_data_held", wd[DW*4 +: DW], 6);
    end
    @(posedge clk);
    #1 wr[4] = 1'b1;
    send(5, 4, 4, 2'b11, 0);
    wait_idle(2);
    sb.push_back('{6, 24'h400, 32'd70});
    sb.push_back('{7, 24'h401, 32'd0});
    cmd(3, 2'd1, 24'h400);
    send(6, 1, 5, 2'b01, 0);
    send(6, 2, 6, 2'b00, 3);
    send(6, 3, 7, 2'b00, 0);
    send(6, 4, 8, 2'b10, 0);
    send(7, 32'h7FFF_FFFF, 2, 2'b01, 0);
    send(7, 1, 2, 2'b10, 0);
    wait_idle(3);
    cmd(0, 2'd1, 24'h10);
    send(0, 7, 7, 2'b01, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midop_reset_ready", rdy, 4'hF);
    chk("midop_reset_no_write", wv, 0);
    @(posedge clk);
    #1;
    sb.push_back('{0, 24'h10, 32'd9});
    sb.push_back('{1, 24'h11, 32'd4});
    cmd(0, 2'd1, 24'h10);
    send(0, 3, 3, 2'b10, 0);
    send(1, 2, 2, 2'b10, 0);
    wait_idle(0);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
